uart_tx_arbiter: RTL

- Shares the single UART transmitter (tx, fed by clk_generator's s_tick) between NUM_REQ byte producers.
- Per transaction it:
  - picks one requester by round-robin;
  - latches that requester's byte onto tx_data;
  - sequences transmit_begin against transmit_active;
  - reports completion or fault to the owning requester.
- Sits between producer logic and tx. tx, rx and clk_generator are unchanged.

---
 rtl/uart_ctrl_pkg.sv | 18 +
 rtl/uart_sync2.sv | 18 +
 rtl/uart_tx_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared encodings and widths for the UART transmit arbiter.
// Pure declarations: no logic, no latency, no flow control.
package uart_ctrl_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    SEND,
    DONE
  } state_t;

  localparam int DATA_W_DEF = 8;

  // Start-timeout counter width; START_TIMEOUT must not exceed 2**TMO_CNT_W.
  localparam int TMO_CNT_W = 16;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single level signal.
// Latency: 2 clk. No backpressure.
module uart_sync2 (
  input  logic clk,
  input  logic d,
  output logic q
);

  logic meta;

  // No reset: the flops keep tracking the tx flags through a reset, so the
  // arbiter sees a frame that is still in flight when reset releases.
  always_ff @(posedge clk) begin
    meta <= d;
    q    <= meta;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART tx among NUM_REQ byte producers.
// Latency: gnt 1 clk after req in IDLE; requesters hold req until gnt, done/fault report the outcome.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int START_TIMEOUT = 65535
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          done,
  output logic [NUM_REQ-1:0]          fault,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  owner,
  output logic [DATA_W-1:0]           tx_data,
  output logic                        transmit_begin,
  input  logic                        transmit_active,
  input  logic                        transmit_over
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic                 act_s;
  logic                 over_s;
  state_t               state;
  logic [IDX_W-1:0]     rr;
  logic [TMO_CNT_W-1:0] cnt;
  logic                 pick_vld;
  logic [IDX_W-1:0]     pick_idx;
  logic [IDX_W-1:0]     owner_nxt;

  uart_sync2 u_sync_act (
    .clk (clk),
    .d   (transmit_active),
    .q   (act_s)
  );

  uart_sync2 u_sync_over (
    .clk (clk),
    .d   (transmit_over),
    .q   (over_s)
  );

  // Descending scan so the last hit is the lowest offset from rr.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[(int'(rr) + k) % NUM_REQ]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'((int'(rr) + k) % NUM_REQ);
      end
    end
  end

  assign owner_nxt = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= WAIT_IDLE;
      rr             <= '0;
      cnt            <= '0;
      gnt            <= '0;
      done           <= '0;
      fault          <= '0;
      busy           <= 1'b0;
      owner          <= '0;
      tx_data        <= '0;
      transmit_begin <= 1'b0;
    end else begin
      gnt   <= '0;
      done  <= '0;
      fault <= '0;
      case (state)
        WAIT_IDLE: begin
          busy <= act_s;
          if (!act_s) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          if (pick_vld) begin
            gnt            <= NUM_REQ'(1) << pick_idx;
            tx_data        <= req_data[pick_idx*DATA_W +: DATA_W];
            owner          <= pick_idx;
            transmit_begin <= 1'b1;
            cnt            <= '0;
            busy           <= 1'b1;
            state          <= START;
          end
        end
        START: begin
          // tx only samples transmit_begin on s_tick, so hold it until active is seen.
          if (act_s) begin
            transmit_begin <= 1'b0;
            state          <= SEND;
          end else if (cnt == TMO_CNT_W'(START_TIMEOUT - 1)) begin
            transmit_begin <= 1'b0;
            fault          <= NUM_REQ'(1) << owner;
            rr             <= owner_nxt;
            state          <= WAIT_IDLE;
          end else begin
            cnt <= cnt + TMO_CNT_W'(1);
          end
        end
        SEND: begin
          if (!act_s || over_s) begin
            state <= DONE;
          end
        end
        DONE: begin
          done  <= NUM_REQ'(1) << owner;
          rr    <= owner_nxt;
          state <= WAIT_IDLE;
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end

endmodule
